ines_stream_loader: RTL and testbench
=====================================

INES_STREAM_LOADER -- requirements
Module: ines_stream_loader

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state.
REQ-003 indata  in  8  ROM file byte from the SD loader.
REQ-004 indata_clk  in  1  one-cycle pulse; indata is valid in that cycle.
REQ-005 mem_addr  out  22  SDRAM byte address of the pending write.
REQ-006 mem_data  out  8  byte to write.
REQ-007 mem_req  out  1  write request; held high until acknowledged.
REQ-008 mem_ack  in  1  memory accepted the current request in this cycle.
REQ-009 mapper_flags  out  32  decoded header, valid once header_valid=1.
REQ-010 header_valid  out  1  header parsed and accepted; sticky.
REQ-011 done  out  1  all PRG/CHR bytes written and acknowledged; sticky.
REQ-012 error  out  1  bad header or overrun; sticky.

Function
REQ-013 States: HEADER, TRAINER, PRG, CHR, DONE, ERROR; state changes only on indata_clk, except the final-ack transition to DONE.
REQ-014 HEADER: count bytes 0-15; bytes 0-3 must be 0x4E,0x45,0x53,0x1A, else go to ERROR on the mismatching byte.
REQ-015 Latch byte4 (prg16k), byte5 (chr8k), byte6 (flags6), byte7 (flags7); ignore bytes 8-15.
REQ-016 After byte 15: prg16k==0 or prg16k>128 -> ERROR; else header_valid=1 and next state is TRAINER if flags6[2]=1, else PRG.
REQ-017 TRAINER: discard exactly 512 bytes, then go to PRG; no memory writes.
REQ-018 PRG: write prg16k*16384 bytes at addresses 0x000000 upward, incrementing by 1.
REQ-019 After the last PRG byte: chr8k==0 -> wait for its ack, then DONE; else go to CHR.
REQ-020 CHR: write chr8k*8192 bytes at 0x200000 upward; after the last byte is acked, go to DONE.
REQ-021 mapper_flags fields: [7:0] prg16k; [15:8] chr8k; [23:16] mapper = {flags7[7:4],flags6[7:4]}; [24] flags6[0] (mirroring); [25] flags6[1] (battery); [26] flags6[3] (four-screen); [27] chr8k==0 (CHR RAM); [31:28]=0.
REQ-022 In PRG/CHR, an indata_clk byte raises mem_req in the next cycle with mem_addr/mem_data loaded; latency 1 cycle.
REQ-023 mem_addr/mem_data hold stable while mem_req=1.
REQ-024 mem_ack with no new byte: mem_req=0 next cycle.
REQ-025 mem_ack and indata_clk in the same cycle: accept the new byte; mem_req stays 1 with the new address/data, no gap cycle.
REQ-026 indata_clk while mem_req=1 and mem_ack=0: overrun; go to ERROR, drop mem_req, do not write the byte.
REQ-027 mem_ack while mem_req=0 is ignored.
REQ-028 Byte counter is 22-bit remaining-count, loaded from header size fields; state advances when it reaches 0; no wrap beyond 0x3FFFFF.
REQ-029 DONE and ERROR are terminal: all further indata_clk are ignored, mem_req=0, done/error hold until reset.
REQ-030 done and error are never both 1.

Reset
REQ-031 On reset: state=HEADER, byte counters=0, mem_req=0, mem_addr=0, mem_data=0, mapper_flags=0, header_valid=0, done=0, error=0.
REQ-032 Reset asserted mid-transfer aborts immediately; a pending request is dropped without waiting for ack.

Verification
REQ-033 Header 4E 45 53 1A 02 01 01 00 + 8x00, then 32768+8192 bytes, mem_ack one cycle after each req. Expected: mapper_flags=0x01000102, PRG at 0x000000-0x007FFF, CHR at 0x200000-0x201FFF, done=1.
REQ-034 flags6=0x04, prg16k=1, chr8k=0. Expected: the 512 trainer bytes produce no req; the first PRG byte goes to 0x000000; after 16384 writes done=1 and mapper_flags[27]=1.
REQ-035 Byte 2=0x54. Expected: error=1 after that byte, no mem_req ever, later bytes ignored.
REQ-036 prg16k=0x81. Expected: error=1 after byte 15, header_valid=0.
REQ-037 Hold mem_ack=0 and send two PRG bytes. Expected: error=1, mem_req=0 the next cycle.
REQ-038 mem_ack coincides with the next indata_clk. Expected: mem_req continuous, addresses N and N+1 are both written.

Source files
------------

// File: rtl/ines_stream_loader.sv
// Streams an iNES ROM image into SDRAM: parses the 16-byte header, skips an
// optional 512-byte trainer, then writes PRG and CHR bytes through a req/ack port.
module ines_stream_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  indata,
    input  logic        indata_clk,
    output logic [21:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mapper_flags,
    output logic        header_valid,
    output logic        done,
    output logic        error
);

    localparam int unsigned ADDR_W = 22;
    localparam int unsigned CNT_W  = 22;
    localparam logic [ADDR_W-1:0] CHR_BASE    = 22'h200000;
    localparam logic [CNT_W-1:0]  TRAINER_LEN = 22'd512;

    typedef enum logic [2:0] {
        S_HEADER,
        S_TRAINER,
        S_PRG,
        S_CHR,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             r_state;
    logic [3:0]         r_hdr_cnt;
    logic [7:0]         r_prg16k;
    logic [7:0]         r_chr8k;
    logic [7:0]         r_flags6;
    logic [3:0]         r_flags7_hi;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [7:0]         r_mem_data;
    logic               r_mem_req;
    logic [31:0]        r_mapper_flags;
    logic               r_header_valid;
    logic               r_done;
    logic               r_error;

    logic [7:0]         w_magic;
    logic [CNT_W-1:0]   w_prg_len;
    logic [CNT_W-1:0]   w_chr_len;
    logic               w_last;
    logic               w_overrun;
    logic               w_acked;

    // Expected signature byte "NES\x1A" for header positions 0-3
    always_comb begin
        w_magic = 8'h00;
        case (r_hdr_cnt[1:0])
            2'd0: w_magic = 8'h4E;
            2'd1: w_magic = 8'h45;
            2'd2: w_magic = 8'h53;
            2'd3: w_magic = 8'h1A;
            default: w_magic = 8'h00;
        endcase
    end

    assign w_prg_len = {r_prg16k, 14'd0};
    assign w_chr_len = {1'b0, r_chr8k, 13'd0};
    assign w_last    = (r_cnt == 22'd1);
    assign w_overrun = indata_clk & r_mem_req & ~mem_ack;
    assign w_acked   = r_mem_req & mem_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_HEADER;
            r_hdr_cnt      <= 4'd0;
            r_prg16k       <= 8'd0;
            r_chr8k        <= 8'd0;
            r_flags6       <= 8'd0;
            r_flags7_hi    <= 4'd0;
            r_cnt          <= '0;
            r_wr_addr      <= '0;
            r_mem_addr     <= '0;
            r_mem_data     <= 8'd0;
            r_mem_req      <= 1'b0;
            r_mapper_flags <= 32'd0;
            r_header_valid <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            case (r_state)
                S_HEADER: begin
                    if (indata_clk) begin
                        r_hdr_cnt <= r_hdr_cnt + 4'd1;
                        case (r_hdr_cnt)
                            4'd4: r_prg16k    <= indata;
                            4'd5: r_chr8k     <= indata;
                            4'd6: r_flags6    <= indata;
                            4'd7: r_flags7_hi <= indata[7:4];
                            default: ;
                        endcase
                        if ((r_hdr_cnt <= 4'd3) && (indata != w_magic)) begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end else if (r_hdr_cnt == 4'd15) begin
                            if ((r_prg16k == 8'd0) || (r_prg16k > 8'd128)) begin
                                r_state <= S_ERROR;
                                r_error <= 1'b1;
                            end else begin
                                r_header_valid <= 1'b1;
                                r_mapper_flags <= {4'd0, (r_chr8k == 8'd0), r_flags6[3],
                                                   r_flags6[1], r_flags6[0], r_flags7_hi,
                                                   r_flags6[7:4], r_chr8k, r_prg16k};
                                r_wr_addr      <= '0;
                                if (r_flags6[2]) begin
                                    r_state <= S_TRAINER;
                                    r_cnt   <= TRAINER_LEN;
                                end else begin
                                    r_state <= S_PRG;
                                    r_cnt   <= w_prg_len;
                                end
                            end
                        end
                    end
                end

                S_TRAINER: begin
                    if (indata_clk) begin
                        r_cnt <= r_cnt - 22'd1;
                        if (w_last) begin
                            r_state <= S_PRG;
                            r_cnt   <= w_prg_len;
                        end
                    end
                end

                S_PRG, S_CHR: begin
                    // A zero count means the last byte is issued and only its ack is awaited
                    if (w_overrun) begin
                        r_state   <= S_ERROR;
                        r_error   <= 1'b1;
                        r_mem_req <= 1'b0;
                    end else if (indata_clk && (r_cnt != '0)) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_wr_addr;
                        r_mem_data <= indata;
                        r_wr_addr  <= r_wr_addr + 22'd1;
                        r_cnt      <= r_cnt - 22'd1;
                        if (w_last && (r_state == S_PRG) && (r_chr8k != 8'd0)) begin
                            r_state   <= S_CHR;
                            r_cnt     <= w_chr_len;
                            r_wr_addr <= CHR_BASE;
                        end
                    end else if (w_acked) begin
                        r_mem_req <= 1'b0;
                        if (r_cnt == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_DONE, S_ERROR: begin
                    r_mem_req <= 1'b0;
                end

                default: begin
                    r_state <= S_HEADER;
                end
            endcase
        end
    end

    assign mem_addr     = r_mem_addr;
    assign mem_data     = r_mem_data;
    assign mem_req      = r_mem_req;
    assign mapper_flags = r_mapper_flags;
    assign header_valid = r_header_valid;
    assign done         = r_done;
    assign error        = r_error;

endmodule

// File: tb/tb_ines_stream_loader.sv
// Bench for ines_stream_loader: header vector table, hand-written handshake
// corner cases, and full-image runs scored against a byte-stream reference model.
module tb_ines_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  indata;
    logic        indata_clk;
    logic [21:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mapper_flags;
    logic        header_valid;
    logic        done;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;

    ines_stream_loader dut (
        .clk          (clk),
        .reset        (reset),
        .indata       (indata),
        .indata_clk   (indata_clk),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mapper_flags (mapper_flags),
        .header_valid (header_valid),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b2;
        logic [7:0]  prg;
        logic [7:0]  chr;
        logic [7:0]  f6;
        logic [7:0]  f7;
        int          err_at;
        logic        hv;
        logic [31:0] flags;
    } hvec_t;

    hvec_t vec[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        indata     = 8'h00;
        indata_clk = 1'b0;
        mem_ack    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        indata     = b;
        indata_clk = 1'b1;
        tick();
        indata_clk = 1'b0;
    endtask

    function automatic logic [7:0] hdr_byte(input logic [7:0] b0, input logic [7:0] b2,
                                            input logic [7:0] prg, input logic [7:0] chr,
                                            input logic [7:0] f6, input logic [7:0] f7,
                                            input int i);
        case (i)
            0: return b0;
            1: return 8'h45;
            2: return b2;
            3: return 8'h1A;
            4: return prg;
            5: return chr;
            6: return f6;
            7: return f7;
            default: return 8'h00;
        endcase
    endfunction

    // Decoded header word built field by field from the header byte meanings
    function automatic logic [31:0] model_flags(input logic [7:0] prg, input logic [7:0] chr,
                                                input logic [7:0] f6, input logic [7:0] f7);
        logic [31:0] f;
        f = 32'd0;
        f[7:0]   = prg;
        f[15:8]  = chr;
        f[23:16] = {f7[7:4], f6[7:4]};
        f[24]    = f6[0];
        f[25]    = f6[1];
        f[26]    = f6[3];
        f[27]    = (chr == 8'd0);
        return f;
    endfunction

    task automatic send_good_header(input logic [7:0] prg, input logic [7:0] chr,
                                    input logic [7:0] f6, input logic [7:0] f7);
        for (int i = 0; i < 16; i++) send_byte(hdr_byte(8'h4E, 8'h53, prg, chr, f6, f7, i));
    endtask

    // Streams a whole image; the model is the file byte array plus the address rule
    task automatic run_file(input string tag, input logic [7:0] prg, input logic [7:0] chr,
                            input logic [7:0] f6, input logic [7:0] f7, input bit rnd);
        logic [7:0]  file[$];
        int          prgb, n_wr, off, sent, wr, early, cyc;
        logic        ack, snd;
        logic [21:0] ea;
        do_reset();
        for (int i = 0; i < 16; i++) file.push_back(hdr_byte(8'h4E, 8'h53, prg, chr, f6, f7, i));
        off = f6[2] ? 16 + 512 : 16;
        prgb = int'(prg) * 16384;
        n_wr = prgb + int'(chr) * 8192;
        for (int i = 16; i < off + n_wr; i++) file.push_back(8'($urandom));
        sent = 0; wr = 0; early = 0; cyc = 0;
        while (!(done || error) && cyc < 60000) begin
            if (mem_req && sent <= off) early++;
            ack = mem_req && (!rnd || $urandom_range(7, 0) != 0);
            snd = (sent < file.size()) && (!mem_req || ack) && (!rnd || $urandom_range(7, 0) != 0);
            if (ack) begin
                if (wr < n_wr) begin
                    ea = (wr < prgb) ? 22'(wr) : 22'h200000 + 22'(wr - prgb);
                    check({tag, "_wr_addr"}, 32'(mem_addr), 32'(ea));
                    check({tag, "_wr_data"}, 32'(mem_data), 32'(file[off + wr]));
                end else begin
                    check({tag, "_extra_write"}, wr, n_wr - 1);
                end
                wr++;
            end
            mem_ack    = ack;
            indata_clk = snd;
            if (snd) begin
                indata = file[sent];
                sent++;
            end
            tick();
            cyc++;
        end
        mem_ack    = 1'b0;
        indata_clk = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_writes"}, wr, n_wr);
        check({tag, "_early_req"}, early, 0);
        check({tag, "_hv"}, 32'(header_valid), 32'd1);
        check({tag, "_flags"}, mapper_flags, model_flags(prg, chr, f6, f7));
        send_byte(8'hEE);
        tick();
        check({tag, "_post_done_req"}, 32'(mem_req), 32'd0);
        check({tag, "_post_done_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        vec[0] = '{8'h4E, 8'h53, 8'h02, 8'h01, 8'h01, 8'h00, 16, 1'b1, 32'h01000102};
        vec[1] = '{8'h4E, 8'h54, 8'h02, 8'h01, 8'h01, 8'h00,  2, 1'b0, 32'h00000000};
        vec[2] = '{8'h4F, 8'h53, 8'h02, 8'h01, 8'h01, 8'h00,  0, 1'b0, 32'h00000000};
        vec[3] = '{8'h4E, 8'h53, 8'h81, 8'h01, 8'h00, 8'h00, 15, 1'b0, 32'h00000000};
        vec[4] = '{8'h4E, 8'h53, 8'h00, 8'h01, 8'h00, 8'h00, 15, 1'b0, 32'h00000000};
        vec[5] = '{8'h4E, 8'h53, 8'h80, 8'h02, 8'hF3, 8'hA0, 16, 1'b1, 32'h03AF0280};
        vec[6] = '{8'h4E, 8'h53, 8'h01, 8'h00, 8'h0C, 8'h10, 16, 1'b1, 32'h0C100001};

        do_reset();
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(mem_data), 32'd0);
        check("rst_flags", mapper_flags, 32'd0);
        check("rst_status", {29'd0, header_valid, done, error}, 32'd0);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int i = 0; i < 16; i++) begin
                send_byte(hdr_byte(vec[v].b0, vec[v].b2, vec[v].prg, vec[v].chr,
                                   vec[v].f6, vec[v].f7, i));
                check($sformatf("v%0d_err_b%0d", v, i), 32'(error), 32'(i >= vec[v].err_at));
                check($sformatf("v%0d_req_b%0d", v, i), 32'(mem_req), 32'd0);
            end
            check($sformatf("v%0d_hv", v), 32'(header_valid), 32'(vec[v].hv));
            check($sformatf("v%0d_flags", v), mapper_flags, vec[v].flags);
            check($sformatf("v%0d_done", v), 32'(done), 32'd0);
            if (vec[v].err_at < 16) begin
                for (int i = 0; i < 4; i++) send_byte(8'h4E);
                check($sformatf("v%0d_ignored_req", v), 32'(mem_req), 32'd0);
                check($sformatf("v%0d_sticky_err", v), 32'(error), 32'd1);
                check($sformatf("v%0d_ignored_hv", v), 32'(header_valid), 32'd0);
            end
        end

        // Back-to-back: ack of byte N coincides with byte N+1, then overrun
        do_reset();
        send_good_header(8'h01, 8'h01, 8'h00, 8'h00);
        send_byte(8'hA5);
        check("b2b_req0", 32'(mem_req), 32'd1);
        check("b2b_addr0", 32'(mem_addr), 32'd0);
        check("b2b_data0", 32'(mem_data), 32'hA5);
        mem_ack = 1'b1;
        send_byte(8'h3C);
        mem_ack = 1'b0;
        check("b2b_req1", 32'(mem_req), 32'd1);
        check("b2b_addr1", 32'(mem_addr), 32'd1);
        check("b2b_data1", 32'(mem_data), 32'h3C);
        send_byte(8'h77);
        check("ovr_error", 32'(error), 32'd1);
        check("ovr_req", 32'(mem_req), 32'd0);
        check("ovr_done", 32'(done), 32'd0);
        send_byte(8'h11);
        check("ovr_ignored_req", 32'(mem_req), 32'd0);
        check("ovr_addr_hold", 32'(mem_addr), 32'd1);

        // Stray ack with no request, then reset asserted with a request pending
        do_reset();
        send_good_header(8'h01, 8'h01, 8'h00, 8'h00);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("stray_ack_req", 32'(mem_req), 32'd0);
        check("stray_ack_err", 32'(error), 32'd0);
        send_byte(8'h5A);
        check("stray_ack_addr", 32'(mem_addr), 32'd0);
        check("stray_ack_req1", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_req", 32'(mem_req), 32'd0);
        check("async_rst_hv", 32'(header_valid), 32'd0);
        check("async_rst_data", 32'(mem_data), 32'd0);
        tick();
        reset = 1'b0;

        run_file("img_2p1c", 8'h02, 8'h01, 8'h01, 8'h00, 1'b0);
        check("img_2p1c_flags_lit", mapper_flags, 32'h01000102);
        run_file("img_trainer", 8'h01, 8'h00, 8'h04, 8'h00, 1'b1);
        check("img_trainer_chrram", 32'(mapper_flags[27]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
